// File: rtl/spi_master_fd.sv
// Full-duplex SPI master: DATA_W-bit words, CPOL/CPHA modes, NUM_CS chip selects, start/busy/done handshake.
// Optional SPI_LOOPBACK_EN adds a loopback input that routes the internal mosi into the receive path.
module spi_master_fd #(
    parameter int DATA_W  = 12,
    parameter int CLK_DIV = 1,
    parameter int NUM_CS  = 1,
    parameter int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              miso,
`ifdef SPI_LOOPBACK_EN
    input  logic              loopback,
`endif
    output logic              sclk,
    output logic              mosi,
    output logic [NUM_CS-1:0] cs_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] dout
);
    localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

    typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [EDGE_W-1:0] edge_reg;
    logic [DATA_W-1:0] tx_reg;
    logic [DATA_W-1:0] rx_reg;
    logic              cpol_reg;
    logic              cpha_reg;
    logic [NUM_CS-1:0] cs_dec;
    logic              rx_bit;
    logic              half_done;
    logic              leading;

    // An out-of-range cs_sel matches no output, so every select stays high.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CS; gi++) begin : g_cs
            assign cs_dec[gi] = (cs_sel != CS_W'(gi));
        end
    endgenerate

`ifdef SPI_LOOPBACK_EN
    logic loop_reg;
    assign rx_bit = loop_reg ? mosi : miso;
`else
    assign rx_bit = miso;
`endif

    assign half_done = (cnt_reg == CNT_LAST);
    assign leading   = ~edge_reg[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            edge_reg  <= '0;
            tx_reg    <= '0;
            rx_reg    <= '0;
            cpol_reg  <= 1'b0;
            cpha_reg  <= 1'b0;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            cs_n      <= '1;
            busy      <= 1'b0;
            done      <= 1'b0;
            dout      <= '0;
`ifdef SPI_LOOPBACK_EN
            loop_reg  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    sclk <= cpol_reg;
                    if (start) begin
                        tx_reg    <= din;
                        cpol_reg  <= cpol;
                        cpha_reg  <= cpha;
                        sclk      <= cpol;
                        cs_n      <= cs_dec;
                        busy      <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= LEAD;
`ifdef SPI_LOOPBACK_EN
                        loop_reg  <= loopback;
`endif
                        if (!cpha) begin
                            mosi <= din[DATA_W-1];
                        end
                    end
                end
                LEAD: begin
                    if (half_done) begin
                        cnt_reg   <= '0;
                        edge_reg  <= '0;
                        state_reg <= XFER;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                XFER: begin
                    if (half_done) begin
                        cnt_reg  <= '0;
                        sclk     <= ~sclk;
                        edge_reg <= edge_reg + 1'b1;
                        // Sample edge is leading for cpha=0 and trailing for cpha=1.
                        if (leading ^ cpha_reg) begin
                            rx_reg <= {rx_reg[DATA_W-2:0], rx_bit};
                        end
                        if (cpha_reg && leading) begin
                            mosi   <= tx_reg[DATA_W-1];
                            tx_reg <= tx_reg << 1;
                        end else if (!cpha_reg && !leading && (edge_reg != EDGE_LAST)) begin
                            mosi   <= tx_reg[DATA_W-2];
                            tx_reg <= tx_reg << 1;
                        end
                        if (edge_reg == EDGE_LAST) begin
                            state_reg <= TRAIL;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                TRAIL: begin
                    if (half_done) begin
                        cnt_reg   <= '0;
                        cs_n      <= '1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        dout      <= rx_reg;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_fd.sv
// Directed bench for spi_master_fd: instance a (CLK_DIV=1, NUM_CS=4) and instance b (CLK_DIV=3, NUM_CS=1).
`timescale 1ns/1ps
module tb_spi_master_fd;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [11:0] din = '0;
    logic        cpol = 1'b0;
    logic        cpha = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [1:0]  cs_sel_a = '0;
    logic [0:0]  cs_sel_b = '0;
    logic        miso_a, miso_b;
    logic        sclk_a, mosi_a, busy_a, done_a;
    logic        sclk_b, mosi_b, busy_b, done_b;
    logic [3:0]  cs_n_a;
    logic [0:0]  cs_n_b;
    logic [11:0] dout_a, dout_b;
`ifdef SPI_LOOPBACK_EN
    logic        loopback = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    spi_master_fd #(.DATA_W(12), .CLK_DIV(1), .NUM_CS(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .din(din), .cs_sel(cs_sel_a),
        .cpol(cpol), .cpha(cpha), .miso(miso_a),
`ifdef SPI_LOOPBACK_EN
        .loopback(loopback),
`endif
        .sclk(sclk_a), .mosi(mosi_a), .cs_n(cs_n_a), .busy(busy_a), .done(done_a), .dout(dout_a)
    );

    spi_master_fd #(.DATA_W(12), .CLK_DIV(3), .NUM_CS(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .din(din), .cs_sel(cs_sel_b),
        .cpol(cpol), .cpha(cpha), .miso(miso_b),
`ifdef SPI_LOOPBACK_EN
        .loopback(1'b0),
`endif
        .sclk(sclk_b), .mosi(mosi_b), .cs_n(cs_n_b), .busy(busy_b), .done(done_b), .dout(dout_b)
    );

    // Slave models: shift a word out MSB first, bit index derived from sclk edges seen this transfer.
    logic [11:0] sword_a = '0;
    logic [11:0] sword_b = '0;
    bit          szero = 1'b0;
    int          ecnt_a = 0, ecnt_b = 0;
    logic        sprev_a = 1'b0, sprev_b = 1'b0;
    logic        bprev_a = 1'b0, bprev_b = 1'b0;

    function automatic logic slave_bit(input logic [11:0] w, input int e, input logic pha);
        int b;
        b = pha ? (e - 1) / 2 : e / 2;
        if (b < 0) b = 0;
        if (b > 11) b = 11;
        return w[11-b];
    endfunction

    always @(negedge clk) begin
        if (!busy_a || !bprev_a) begin
            ecnt_a = 0;
            sprev_a = sclk_a;
        end else if (sclk_a != sprev_a) begin
            ecnt_a++;
            sprev_a = sclk_a;
        end
        bprev_a = busy_a;
        miso_a = szero ? 1'b0 : slave_bit(sword_a, ecnt_a, cpha);
    end

    always @(negedge clk) begin
        if (!busy_b || !bprev_b) begin
            ecnt_b = 0;
            sprev_b = sclk_b;
        end else if (sclk_b != sprev_b) begin
            ecnt_b++;
            sprev_b = sclk_b;
        end
        bprev_b = busy_b;
        miso_b = slave_bit(sword_b, ecnt_b, cpha);
    end

    // Starts one transfer and watches ncyc cycles; sample k is taken after posedge N+k (cycle N+k+1).
    task automatic run_xfer(input bit use_b, input logic [11:0] d, input logic [11:0] sw, input int csi,
                            input logic pol, input logic pha, input int tdiv, input int ncyc, input bit poke,
                            output int done_cyc, output int n_done, output logic [11:0] mosi_w,
                            output int n_edges, output int gap_err, output int cs_err,
                            output int busy_after, output logic [11:0] rx);
        logic       prev, s_sclk, s_mosi, s_busy, s_done, s_cslow, p;
        logic [11:0] s_dout;
        logic [3:0] one;
        int         last_e;
        one = 4'b0001;
        din = d; cpol = pol; cpha = pha; cs_sel_a = csi[1:0]; cs_sel_b = 1'b0;
        if (use_b) sword_b = sw; else sword_a = sw;
        done_cyc = 0; n_done = 0; mosi_w = '0; n_edges = 0; gap_err = 0; cs_err = 0;
        busy_after = 0; rx = '0; prev = pol; last_e = -1;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            p = poke && (k == 3 || k == 10 || k == 20);
            if (use_b) start_b = p; else start_a = p;
            if (use_b) begin
                s_sclk = sclk_b; s_mosi = mosi_b; s_busy = busy_b; s_done = done_b;
                s_cslow = (cs_n_b == 1'b0); s_dout = dout_b;
            end else begin
                s_sclk = sclk_a; s_mosi = mosi_a; s_busy = busy_a; s_done = done_a;
                s_cslow = (cs_n_a == ~(one << csi)); s_dout = dout_a;
            end
            if (s_done) begin
                n_done++;
                if (done_cyc == 0) begin
                    done_cyc = k + 1;
                    rx = s_dout;
                end
            end else if (n_done > 0 && s_busy) begin
                busy_after++;
            end
            if (s_busy && !s_cslow) cs_err++;
            if (s_sclk != prev) begin
                n_edges++;
                if (last_e >= 0 && (k - last_e) != tdiv) gap_err++;
                last_e = k;
                if ((s_sclk != pol) == !pha) mosi_w = {mosi_w[10:0], s_mosi};
                prev = s_sclk;
            end
        end
        $display("xfer dut=%s din=%h slave=%h cpol=%0b cpha=%0b done_cycle=%0d dout=%h mosi=%h edges=%0d",
                 use_b ? "b" : "a", d, sw, pol, pha, done_cyc, rx, mosi_w, n_edges);
    endtask

    int          r_done_cyc, r_n_done, r_edges, r_gap, r_cs, r_busy_after;
    logic [11:0] r_mosi, r_rx;

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (cs_n_a !== 4'hF) begin failures++; $display("FAIL reset_cs_n_a got=%h exp=f", cs_n_a); end
        checks++; if (cs_n_b !== 1'b1) begin failures++; $display("FAIL reset_cs_n_b got=%h exp=1", cs_n_b); end
        checks++; if (sclk_a !== 1'b0 || mosi_a !== 1'b0) begin failures++; $display("FAIL reset_sclk_mosi got=%b%b exp=00", sclk_a, mosi_a); end
        checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%b%b exp=00", busy_a, done_a); end
        checks++; if (dout_a !== 12'h000) begin failures++; $display("FAIL reset_dout got=%h exp=000", dout_a); end
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_mode0();
        run_xfer(1'b0, 12'hAAA, 12'h5A5, 0, 1'b0, 1'b0, 1, 40, 1'b0,
                 r_done_cyc, r_n_done, r_mosi, r_edges, r_gap, r_cs, r_busy_after, r_rx);
        checks++; if (r_done_cyc != 27) begin failures++; $display("FAIL mode0_latency got=%0d exp=27", r_done_cyc); end
        checks++; if (r_n_done != 1) begin failures++; $display("FAIL mode0_done_count got=%0d exp=1", r_n_done); end
        checks++; if (r_mosi !== 12'hAAA) begin failures++; $display("FAIL mode0_mosi got=%h exp=aaa", r_mosi); end
        checks++; if (r_rx !== 12'h5A5) begin failures++; $display("FAIL mode0_dout got=%h exp=5a5", r_rx); end
        checks++; if (r_edges != 24 || r_gap != 0) begin failures++; $display("FAIL mode0_edges got=%0d gaperr=%0d exp=24/0", r_edges, r_gap); end
        checks++; if (r_cs != 0) begin failures++; $display("FAIL mode0_cs_low got=%0d exp=0", r_cs); end
        checks++; if (dout_a !== 12'h5A5 || cs_n_a !== 4'hF) begin failures++; $display("FAIL mode0_hold got=%h/%h exp=5a5/f", dout_a, cs_n_a); end
    endtask

    task automatic test_mode3();
        run_xfer(1'b1, 12'h000, 12'hFFF, 0, 1'b1, 1'b1, 3, 100, 1'b0,
                 r_done_cyc, r_n_done, r_mosi, r_edges, r_gap, r_cs, r_busy_after, r_rx);
        checks++; if (r_done_cyc != 79) begin failures++; $display("FAIL mode3_latency got=%0d exp=79", r_done_cyc); end
        checks++; if (r_edges != 24 || r_gap != 0) begin failures++; $display("FAIL mode3_edges got=%0d gaperr=%0d exp=24/0", r_edges, r_gap); end
        checks++; if (r_mosi !== 12'h000) begin failures++; $display("FAIL mode3_mosi got=%h exp=000", r_mosi); end
        checks++; if (r_rx !== 12'hFFF) begin failures++; $display("FAIL mode3_dout got=%h exp=fff", r_rx); end
        checks++; if (sclk_b !== 1'b1) begin failures++; $display("FAIL mode3_sclk_idle got=%b exp=1", sclk_b); end
        checks++; if (r_cs != 0 || r_n_done != 1) begin failures++; $display("FAIL mode3_cs_done got=%0d/%0d exp=0/1", r_cs, r_n_done); end
    endtask

    task automatic test_start_while_busy();
        run_xfer(1'b0, 12'h3C5, 12'h9A6, 1, 1'b0, 1'b1, 1, 40, 1'b1,
                 r_done_cyc, r_n_done, r_mosi, r_edges, r_gap, r_cs, r_busy_after, r_rx);
        checks++; if (r_done_cyc != 27) begin failures++; $display("FAIL busy_latency got=%0d exp=27", r_done_cyc); end
        checks++; if (r_n_done != 1 || r_busy_after != 0) begin failures++; $display("FAIL busy_single_done got=%0d/%0d exp=1/0", r_n_done, r_busy_after); end
        checks++; if (r_mosi !== 12'h3C5) begin failures++; $display("FAIL busy_mosi got=%h exp=3c5", r_mosi); end
        checks++; if (r_rx !== 12'h9A6) begin failures++; $display("FAIL busy_dout got=%h exp=9a6", r_rx); end
        checks++; if (r_cs != 0) begin failures++; $display("FAIL busy_cs_low got=%0d exp=0", r_cs); end
    endtask

    task automatic test_back_to_back();
        int d1, d2, n_done, cs_err;
        logic [11:0] rx1, rx2;
        logic [3:0]  cs_at_done, cs_after;
        logic        busy_after;
        d1 = 0; d2 = 0; n_done = 0; cs_err = 0; rx1 = '0; rx2 = '0;
        cs_at_done = '0; cs_after = '0; busy_after = 1'b0;
        din = 12'h123; cpol = 1'b0; cpha = 1'b0; cs_sel_a = 2'd2; sword_a = 12'h3C3; start_a = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k == 0) begin
                cs_sel_a = 2'd3;
                din = 12'hE1D;
            end
            if (k < 26 && cs_n_a !== 4'b1011) cs_err++;
            if (k == 26) begin
                cs_at_done = cs_n_a;
                sword_a = 12'h0F0;
            end
            if (k == 27) begin
                cs_after = cs_n_a;
                busy_after = busy_a;
                start_a = 1'b0;
            end
            if (done_a) begin
                n_done++;
                if (d1 == 0) begin d1 = k + 1; rx1 = dout_a; end
                else if (d2 == 0) begin d2 = k + 1; rx2 = dout_a; end
            end
        end
        $display("b2b first_done=%0d dout=%h second_done=%0d dout=%h", d1, rx1, d2, rx2);
        checks++; if (d1 != 27) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=27", d1); end
        checks++; if (cs_err != 0) begin failures++; $display("FAIL b2b_cs2_low got=%0d exp=0", cs_err); end
        checks++; if (cs_at_done !== 4'hF) begin failures++; $display("FAIL b2b_cs_gap got=%h exp=f", cs_at_done); end
        checks++; if (cs_after !== 4'b0111 || busy_after !== 1'b1) begin failures++; $display("FAIL b2b_cs3_low got=%h/%b exp=7/1", cs_after, busy_after); end
        checks++; if (d2 != 54) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=54", d2); end
        checks++; if (rx1 !== 12'h3C3 || rx2 !== 12'h0F0) begin failures++; $display("FAIL b2b_dout got=%h/%h exp=3c3/0f0", rx1, rx2); end
        checks++; if (n_done != 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", n_done); end
    endtask

    task automatic test_reset_mid();
        int n_done;
        n_done = 0;
        din = 12'h5F0; cpol = 1'b1; cpha = 1'b0; cs_sel_a = 2'd0; sword_a = 12'hABC; start_a = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            start_a = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (cs_n_a !== 4'hF || busy_a !== 1'b0) begin failures++; $display("FAIL rstmid_cs_busy got=%h/%b exp=f/0", cs_n_a, busy_a); end
        checks++; if (sclk_a !== 1'b0 || done_a !== 1'b0) begin failures++; $display("FAIL rstmid_sclk_done got=%b/%b exp=0/0", sclk_a, done_a); end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done_a) n_done++;
        end
        $display("reset mid-transfer, done pulses afterwards=%0d", n_done);
        checks++; if (n_done != 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", n_done); end
        run_xfer(1'b0, 12'h36C, 12'h1E7, 0, 1'b0, 1'b0, 1, 40, 1'b0,
                 r_done_cyc, r_n_done, r_mosi, r_edges, r_gap, r_cs, r_busy_after, r_rx);
        checks++; if (r_done_cyc != 27 || r_n_done != 1) begin failures++; $display("FAIL rstmid_rerun_done got=%0d/%0d exp=27/1", r_done_cyc, r_n_done); end
        checks++; if (r_rx !== 12'h1E7 || r_mosi !== 12'h36C) begin failures++; $display("FAIL rstmid_rerun_data got=%h/%h exp=1e7/36c", r_rx, r_mosi); end
    endtask

`ifdef SPI_LOOPBACK_EN
    task automatic test_loopback();
        szero = 1'b1;
        loopback = 1'b1;
        run_xfer(1'b0, 12'hC3F, 12'h000, 0, 1'b0, 1'b0, 1, 40, 1'b0,
                 r_done_cyc, r_n_done, r_mosi, r_edges, r_gap, r_cs, r_busy_after, r_rx);
        checks++; if (r_rx !== 12'hC3F || r_mosi !== 12'hC3F) begin failures++; $display("FAIL loop_on got=%h/%h exp=c3f/c3f", r_rx, r_mosi); end
        loopback = 1'b0;
        run_xfer(1'b0, 12'hC3F, 12'h000, 0, 1'b0, 1'b0, 1, 40, 1'b0,
                 r_done_cyc, r_n_done, r_mosi, r_edges, r_gap, r_cs, r_busy_after, r_rx);
        checks++; if (r_rx !== 12'h000) begin failures++; $display("FAIL loop_off got=%h exp=000", r_rx); end
        szero = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_mode0();
        test_mode3();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
`ifdef SPI_LOOPBACK_EN
        test_loopback();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_master_fd.md
Name: spi_master_fd

Overview:
- Parametrised full-duplex SPI master; next generation of the 12-bit transmit-only master.
- Adds configurable word width, sclk divider, all four CPOL/CPHA modes, multiple chip selects, simultaneous MISO capture and a start/busy/done handshake.
- Sits between a register/control block (word source/sink) and off-chip SPI slaves.

Parameters:
- DATA_W, 12, bits per transfer (>=2)
- CLK_DIV, 1, clk cycles per sclk half-period (>=1); sclk freq = clk / (2*CLK_DIV)
- NUM_CS, 1, number of active-low chip selects (>=1)
- CS_W, max(1,$clog2(NUM_CS)), width of cs_sel

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  request a transfer; sampled only in IDLE
- din  in  DATA_W  word to transmit, MSB first
- cs_sel  in  CS_W  slave select index
- cpol  in  1  sclk idle level
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
- miso  in  1  serial data from slave
- sclk  out  1  serial clock
- mosi  out  1  serial data to slave
- cs_n  out  NUM_CS  chip selects, active low
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse when transfer completes
- dout  out  DATA_W  received word; valid from done, held until next done

Behaviour:
- Reset (sync, rst high at posedge): state IDLE, cs_n all 1, sclk 0, mosi 0, busy 0, done 0, dout 0, latched cpol/cpha 0. A reset mid-transfer aborts the transfer at that edge; no done pulse is issued.
- Acceptance: in IDLE with start=1 at posedge N, latch din, cs_sel, cpol, cpha. Go to LEAD at N+1 with busy=1 and cs_n[cs_sel]=0.
  - If cs_sel>=NUM_CS, the transfer still runs with all cs_n high.
  - cpol/cpha changes during a transfer are ignored.
- No din value is special: a zero word is transmitted normally.
- T = CLK_DIV. States:
  - IDLE: sclk=latched cpol; mosi holds its last value.
  - LEAD, T cycles: cs setup. mosi=din[DATA_W-1] on entry when cpha=0.
  - XFER, 2*DATA_W*T cycles: sclk toggles every T cycles, giving 2*DATA_W edges. Leading edge = away from cpol; trailing edge = back to cpol.
    - cpha=0: sample miso on each leading edge. Shift mosi to the next bit on each trailing edge except the last.
    - cpha=1: drive the next bit on each leading edge (the first leading edge drives the MSB). Sample miso on each trailing edge.
    - Sampled bits shift into a receive register MSB first.
  - TRAIL, T cycles: sclk=cpol, cs held low (hold time).
  - Exit: cs_n all 1, busy=0, done=1 for exactly one cycle, dout=receive register; state IDLE.
- Latency: done is high in cycle N+1+(2*DATA_W+2)*T.
- Back-to-back: start is honoured in the done cycle, so cs_n deasserts for at least 1 cycle between words.
- start while busy: ignored, not queued.
- sclk is registered (glitch-free); mosi and cs_n are registered.

Optional Feature:
- Macro: SPI_LOOPBACK_EN.
- Defined: adds input port loopback (1 bit). When loopback=1 (latched at start), the receive path samples the internal mosi instead of miso, so dout==din after done. Pins behave as normal.
- Undefined: no loopback port; receive path always samples miso.

Test Plan:
- Mode 0, DATA_W=12, CLK_DIV=1, din=0xAAA, slave model drives 0x5A5 -> mosi bit sequence 1,0,1,0…; dout=0x5A5; done exactly 27 cycles after the start edge; cs_n[0] low throughout LEAD..TRAIL.
- Mode 3 (cpol=1, cpha=1), CLK_DIV=3, din=0x000 -> sclk idles high; 24 edges at 3-cycle spacing; mosi all 0; dout matches slave word 0xFFF; zero word transmitted.
- start re-asserted at several points while busy -> no effect on the transfer or timing; exactly one done pulse.
- Back-to-back: start held high continuously with NUM_CS=4, cs_sel=2 then 3 -> second transfer accepted in the done cycle; cs_n[2] high for 1 cycle before cs_n[3] falls; other cs_n stay 1.
- rst pulsed mid-XFER -> next cycle cs_n all 1, sclk 0, busy 0, no done pulse; the following start runs a clean full transfer.
- SPI_LOOPBACK_EN defined, loopback=1, din=0xC3F, miso tied 0 -> dout=0xC3F; with loopback=0 -> dout=0x000.
